// File: rtl/program_loader.sv
// Streams a length-prefixed image into instruction memory and holds the core in reset until it is complete.
// Optional trailing checksum verification is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] FULL_N = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      n_q, n_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  core_reset_q, core_reset_d;
    logic                  xfer;
    logic                  restart;
    logic [CNT_W-1:0]      count_inc;

    assign xfer      = in_valid & ready_q;
    assign restart   = start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERROR));
    assign count_inc = count_q + CNT_W'(1);

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  error_q, error_d;

    // Running modulo-2^DATA_WIDTH sum of accepted payload bytes
    always_comb begin
        sum_d = sum_q;
        if (restart) begin
            sum_d = '0;
        end else if ((state_q == S_LOAD) && xfer) begin
            sum_d = sum_q + in_data;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        n_d     = n_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN;
                    count_d = '0;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    n_d     = (in_data == '0) ? FULL_N : CNT_W'(in_data);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    addr_d  = count_q[ADDR_WIDTH-1:0];
                    wdata_d = in_data;
                    we_d    = 1'b1;
                    count_d = count_inc;
                    if (count_inc == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) begin
                    state_d = (in_data == sum_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with the state register
    assign ready_d      = (state_d == S_LEN) | (state_d == S_LOAD) | (state_d == S_CHECK);
    assign busy_d       = ready_d;
    assign done_d       = (state_d == S_DONE);
    assign core_reset_d = (state_d != S_DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            n_q          <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            n_q          <= n_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            core_reset_q <= core_reset_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    assign error_d = (state_d == S_ERROR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_q   <= '0;
            error_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign in_ready     = ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign core_reset   = core_reset_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign words_loaded = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected memory writes are queued as bytes are sent and
// retired by a write monitor; status outputs are checked inline by each scenario task.
module tb_program_loader;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       imem_we;
    logic [7:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       core_reset;
    logic       busy;
    logic       done;
    logic       error;
    logic [8:0] words_loaded;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] payload [256];
    int         checks = 0;
    int         errors = 0;

    program_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset   (core_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Write monitor: every imem_we pulse must match the oldest queued expectation
    initial begin
        forever begin
            @(negedge clock);
            if (imem_we === 1'b1) begin
                wr_t exp_w;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL imem_write: unexpected write addr=%02h data=%02h", imem_addr, imem_wdata);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({imem_addr, imem_wdata} !== {exp_w.addr, exp_w.data}) begin
                        errors++;
                        $display("FAIL imem_write: got addr=%02h data=%02h, want addr=%02h data=%02h",
                                 imem_addr, imem_wdata, exp_w.addr, exp_w.data);
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Offer one byte, optionally after idle gap cycles during which start may be pulsed
    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
        int t = 0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clock);
            start = poke;
        end
        @(negedge clock);
        start    = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b, want 1", in_ready);
        end
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic load_image(input int n, input int cks_off, input int gap, input bit poke);
        logic [7:0] sum = 8'h00;
        pulse_start();
        send_byte(8'(n), 0, 1'b0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({8'(i), payload[i]});
            sum = sum + payload[i];
            send_byte(payload[i], gap, poke);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(sum + 8'(cks_off), 0, 1'b0);
`endif
    endtask

    // Wait (bounded) for the load to finish, then check the terminal status
    task automatic check_end(input string name, input bit want_done, input int words);
        int t = 0;
        while (done !== 1'b1 && error !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        @(negedge clock);
        checks++;
        if (done !== want_done || error !== !want_done) begin
            errors++;
            $display("FAIL %s_status: done=%b error=%b, want done=%b error=%b", name, done, error, want_done, !want_done);
        end
        checks++;
        if (core_reset !== !want_done) begin
            errors++;
            $display("FAIL %s_core_reset: got %b, want %b", name, core_reset, !want_done);
        end
        checks++;
        if (words_loaded !== 9'(words)) begin
            errors++;
            $display("FAIL %s_words: got %0d, want %0d", name, words_loaded, words);
        end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_flags: in_ready=%b busy=%b, want 0 0", name, in_ready, busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_writes_pending: %0d expected writes never seen, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        #2;
        checks++;
        if ({in_ready, core_reset, imem_we, done, error, busy} !== 6'b010000) begin
            errors++;
            $display("FAIL reset_flags: ready/core_rst/we/done/err/busy=%b, want 010000",
                     {in_ready, core_reset, imem_we, done, error, busy});
        end
        checks++;
        if (words_loaded !== 9'd0) begin
            errors++;
            $display("FAIL reset_words: got %0d, want 0", words_loaded);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (core_reset !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: core_reset=%b in_ready=%b, want 1 0", core_reset, in_ready);
        end
    endtask

    task automatic test_basic();
        payload[0] = 8'h11;
        payload[1] = 8'h22;
        payload[2] = 8'h33;
        load_image(3, 0, 0, 1'b0);
        check_end("basic", 1'b1, 3);
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        payload[0] = 8'h11;
        payload[1] = 8'h22;
        payload[2] = 8'h33;
        load_image(3, 1, 0, 1'b0);
        check_end("bad_cks", 1'b0, 3);
        repeat (3) @(negedge clock);
        checks++;
        if (error !== 1'b1 || core_reset !== 1'b1) begin
            errors++;
            $display("FAIL bad_cks_sticky: error=%b core_reset=%b, want 1 1", error, core_reset);
        end
        load_image(3, 0, 0, 1'b0);
        check_end("recover", 1'b1, 3);
    endtask
`endif

    task automatic test_full_256();
        for (int i = 0; i < 256; i++) payload[i] = 8'(i);
        load_image(256, 0, 0, 1'b0);
        check_end("full256", 1'b1, 256);
    endtask

    task automatic test_stall_and_start();
        for (int i = 0; i < 5; i++) payload[i] = 8'($urandom_range(0, 255));
        load_image(5, 0, 1, 1'b1);
        check_end("stall", 1'b1, 5);
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 5; i++) payload[i] = 8'(8'hA0 + i);
        pulse_start();
        checks++;
        if (core_reset !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart_flags: core_reset=%b done=%b, want 1 0", core_reset, done);
        end
        send_byte(8'd5, 0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({8'(i), payload[i]});
            send_byte(payload[i], 0, 1'b0);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b1 || words_loaded !== 9'd2) begin
            errors++;
            $display("FAIL midload_state: busy=%b words=%0d, want 1 2", busy, words_loaded);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, core_reset, in_ready, done} !== 4'b0100 || words_loaded !== 9'd0) begin
            errors++;
            $display("FAIL midload_reset: busy/core_rst/ready/done=%b words=%0d, want 0100 0",
                     {busy, core_reset, in_ready, done}, words_loaded);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midload_writes: %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clock);
        reset = 1'b0;
        load_image(5, 0, 0, 1'b0);
        check_end("reload", 1'b1, 5);
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_full_256();
        test_stall_and_start();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
